// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver, mid-bit sampling, byte plus one-clock ready/error strobes
module uart_rx_byte #(
  parameter int CLK_HZ = 12000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_pin,
  output logic [7:0] rx_data,
  output logic       rx_data_rdy,
  output logic       rx_frm_err,
  output logic       rx_busy
);
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_e;

  state_e          state_q, state_d;
  logic            s1_q, s2_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d, data_q, data_d;
  logic            rdy_q, rdy_d, err_q, err_d;
  logic            rx_s, half_done, bit_done, sample;

  assign rx_s      = s2_q;
  assign half_done = cnt_q == CW'(HALF_BIT - 1);
  assign bit_done  = cnt_q == CW'(CLKS_PER_BIT - 1);

  // sync flops reset high so a reset never looks like a start edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q    <= rx_pin;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = rx_s ? IDLE : START;
      START:     state_d = !half_done ? START : (rx_s ? IDLE : DATA);
      DATA:      state_d = (bit_done && idx_q == 3'd7) ? STOP : DATA;
      STOP:      state_d = !bit_done ? STOP : (rx_s ? IDLE : WAIT_IDLE);
      WAIT_IDLE: state_d = rx_s ? IDLE : WAIT_IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // counter only runs while timing a bit and reloads on every sample
  always_comb begin
    sample  = (state_q == START && half_done) || ((state_q == DATA || state_q == STOP) && bit_done);
    cnt_d   = (state_q inside {START, DATA, STOP} && !sample) ? cnt_q + CW'(1) : '0;
    idx_d   = state_q == DATA ? idx_q + 3'(bit_done) : 3'd0;
    shift_d = shift_q;
    if (state_q == DATA && bit_done) shift_d[idx_q] = rx_s;
    rdy_d   = state_q == STOP && bit_done && rx_s;
    err_d   = state_q == STOP && bit_done && !rx_s;
    data_d  = rdy_d ? shift_q : data_q;
  end

  assign rx_data     = data_q;
  assign rx_data_rdy = rdy_q;
  assign rx_frm_err  = err_q;
  assign rx_busy     = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: directed plus random frames against an expected-event queue model
module tb_uart_rx_byte;
  logic       clk = 1'b0, rst = 1'b0, rx_pin = 1'b1;
  logic [7:0] rx_data;
  logic       rx_data_rdy, rx_frm_err, rx_busy;

  int         checks = 0, errors = 0;
  int         cyc = 0, start_cyc = 0, busy_cyc = 0, rdy_cnt = 0, err_cnt = 0;
  bit         lat_on = 1'b0, prev_any = 1'b0;
  logic [7:0] model_data = 8'h00;
  logic [8:0] exp_q[$];
  logic [8:0] ev;

  uart_rx_byte dut (
    .clk(clk), .rst(rst), .rx_pin(rx_pin), .rx_data(rx_data),
    .rx_data_rdy(rx_data_rdy), .rx_frm_err(rx_frm_err), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // caller must be at a falling edge; leaves the line at the stop-bit level
  task automatic send(input logic [7:0] b, input int cpb, input bit stop_ok);
    rx_pin = 1'b0;
    start_cyc = cyc;
    repeat (cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      repeat (cpb) @(negedge clk);
    end
    rx_pin = stop_ok;
    repeat (cpb) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    repeat (300) @(negedge clk);
    check(tag, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      prev_any   = 1'b0;
      model_data = 8'h00;
    end else begin
      if (rx_busy) busy_cyc++;
      if (rx_data_rdy || rx_frm_err) begin
        check("excl", rx_data_rdy && rx_frm_err, 0);
        check("dbl", prev_any, 0);
        if (exp_q.size() == 0) check("spurious", 1, 0);
        else begin
          ev = exp_q.pop_front();
          check("kind", rx_frm_err, ev[8]);
          if (ev[8]) check("hold", rx_data, model_data);
          else begin
            check("data", rx_data, ev[7:0]);
            model_data = ev[7:0];
            if (lat_on) check("lat", cyc - start_cyc, 52 + 9 * 104 + 3);
          end
        end
        rdy_cnt += int'(rx_data_rdy);
        err_cnt += int'(rx_frm_err);
      end
      prev_any = rx_data_rdy || rx_frm_err;
    end
  end

  initial begin
    int b0, e0, r0, cpb, gap;
    logic [7:0] b;
    bit ok;
    @(negedge clk);
    for (int i = 0; i < 50; i++) begin
      rx_pin = 1'($urandom);
      @(negedge clk);
    end
    check("rst_data", rx_data, 0);
    check("rst_busy", rx_busy, 0);
    check("rst_rdy", rx_data_rdy, 0);
    rx_pin = 1'b1;
    rst = 1'b1;
    repeat (200) @(negedge clk);
    check("idle_strobes", rdy_cnt + err_cnt, 0);
    check("idle_busy", rx_busy, 0);
    check("idle_data", rx_data, 0);

    exp_q.push_back({1'b0, 8'h41});
    lat_on = 1'b1;
    b0 = busy_cyc;
    e0 = err_cnt;
    send(8'h41, 104, 1'b1);
    drain("single_q");
    lat_on = 1'b0;
    check("busy_len", (busy_cyc - b0) inside {[980:1000]}, 1);
    check("single_err", err_cnt - e0, 0);

    foreach (exp_q[i]) ;
    exp_q.push_back({1'b0, 8'h31});
    exp_q.push_back({1'b0, 8'h32});
    exp_q.push_back({1'b0, 8'h0D});
    r0 = rdy_cnt;
    send(8'h31, 104, 1'b1);
    send(8'h32, 104, 1'b1);
    send(8'h0D, 104, 1'b1);
    drain("b2b_q");
    check("b2b_cnt", rdy_cnt - r0, 3);

    e0 = rdy_cnt + err_cnt;
    rx_pin = 1'b0;
    repeat (20) @(negedge clk);
    rx_pin = 1'b1;
    repeat (100) @(negedge clk);
    check("glitch_busy", rx_busy, 0);
    check("glitch_strobes", rdy_cnt + err_cnt - e0, 0);
    exp_q.push_back({1'b0, 8'h55});
    send(8'h55, 104, 1'b1);
    drain("glitch_q");

    e0 = err_cnt;
    r0 = rdy_cnt;
    exp_q.push_back({1'b1, 8'h00});
    send(8'hA5, 104, 1'b0);
    repeat (3000) @(negedge clk);
    check("brk_err", err_cnt - e0, 1);
    check("brk_rdy", rdy_cnt - r0, 0);
    check("brk_busy", rx_busy, 1);
    check("brk_data", rx_data, 8'h55);
    rx_pin = 1'b1;
    repeat (50) @(negedge clk);
    exp_q.push_back({1'b0, 8'h7E});
    send(8'h7E, 104, 1'b1);
    drain("brk_q");

    exp_q.push_back({1'b0, 8'hC3});
    send(8'hC3, 100, 1'b1);
    repeat (200) @(negedge clk);
    exp_q.push_back({1'b0, 8'hC3});
    send(8'hC3, 108, 1'b1);
    drain("baud_q");

    rx_pin = 1'b0;
    repeat (104) @(negedge clk);
    rx_pin = 1'b1;
    repeat (104) @(negedge clk);
    rx_pin = 1'b0;
    repeat (50) @(negedge clk);
    check("mid_busy", rx_busy, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", rx_busy, 0);
    check("mid_rst_data", rx_data, 0);
    check("mid_rst_strobe", rx_data_rdy || rx_frm_err, 0);
    @(negedge clk);
    for (int i = 0; i < 200; i++) begin
      rx_pin = 1'($urandom);
      @(negedge clk);
    end
    rx_pin = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (50) @(negedge clk);
    exp_q.push_back({1'b0, 8'h96});
    send(8'h96, 104, 1'b1);
    drain("mid_q");

    for (int n = 0; n < 20; n++) begin
      b   = 8'($urandom);
      cpb = $urandom_range(100, 108);
      ok  = $urandom_range(0, 4) != 0;
      gap = $urandom_range(0, 30);
      exp_q.push_back({!ok, ok ? b : 8'h00});
      send(b, cpb, ok);
      rx_pin = 1'b1;
      repeat (ok ? gap : cpb + gap) @(negedge clk);
    end
    drain("rand_q");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- Serial receiver that sits directly upstream of the lab top level.
- Converts the asynchronous UART RX pin (8N1) into a parallel byte plus a one-clock ready strobe.
- Its outputs drive bu_rx_data / bu_rx_data_rdy, which the top level registers and forwards to its command controller.
- Runs on the 12 MHz system clock with no other clock domain.

Parameters:
- CLK_HZ, 12000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bits per second.
- CLKS_PER_BIT, CLK_HZ/BAUD (integer truncation, 104 at defaults), clocks per bit period.
- HALF_BIT, CLKS_PER_BIT/2 (52 at defaults), clocks from start-edge detect to the start-bit mid-point check.

Ports:
- clk  input  1  global system clock; all flops on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- rx_pin  input  1  raw UART line; idles high; asynchronous to clk.
- rx_data  output  8  last correctly framed byte; LSB first on the wire.
- rx_data_rdy  output  1  one-clock strobe; rx_data is valid from this cycle on.
- rx_frm_err  output  1  one-clock strobe when the stop bit is sampled low.
- rx_busy  output  1  high while a frame is in progress (any state other than IDLE).

Behaviour:
- Reset:
  - Asynchronous and active-low; entered immediately on rst=0.
  - rx_data=8'h00, rx_data_rdy=0, rx_frm_err=0, rx_busy=0.
  - Synchronizer flops set to 1 (idle line). State=IDLE; bit counter and clock counter cleared.
  - Reset released mid-frame: receiver restarts in IDLE and ignores the rest of the frame. The next falling edge may resync on a data bit; this is accepted.
- Input sync:
  - rx_pin passes through two flops before use; rx_s is the second flop.
  - All timing below is referenced to rx_s. This adds 2 clocks of fixed latency.
- State machine (IDLE, START, DATA, STOP, WAIT_IDLE):
  - IDLE: on rx_s=0, go to START and clear the clock counter.
  - START: count HALF_BIT-1 clocks, then sample rx_s.
    - rx_s=1: glitch; return to IDLE with no output.
    - rx_s=0: go to DATA, clear the clock counter and bit index.
  - DATA: every CLKS_PER_BIT clocks, sample rx_s into the shift register at position bit index (LSB first) and increment the index. After the 8th sample, go to STOP.
  - STOP: after CLKS_PER_BIT clocks, sample rx_s.
    - rx_s=1: rx_data <= shift register; rx_data_rdy=1 for exactly one cycle (the cycle after the sample). Go to IDLE.
    - rx_s=0: rx_frm_err=1 for one cycle; rx_data is unchanged; go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s=1, then go to IDLE. A held-low break therefore reports exactly one error.
- Timing:
  - Return to IDLE happens at the stop-bit mid-point, so a back-to-back frame is caught.
  - A start edge arriving half a bit after the stop mid-point must be received correctly.
- Counters:
  - Clock counter is wide enough for CLKS_PER_BIT-1 (7 bits at defaults). It reloads to 0 on each sample and never wraps uncontrolled.
  - Bit index is 3 bits; the transition to STOP is taken on index 7.
- Strobes:
  - rx_data_rdy and rx_frm_err are never high in the same cycle.
  - Neither is ever high for two consecutive cycles.
- Data hold: rx_data holds its value between frames. The consumer may sample it any time after the strobe.
- Latency: from the rx_pin mid-stop-bit point to rx_data_rdy is 3 clocks (2 sync + 1 register).

Test Plan:
- Reset: drive rst=0 with rx_pin toggling, then release -> all outputs 0, rx_busy=0, no strobe for 200 clocks with rx_pin=1.
- Single byte: send 8'h41 ('A') at 104 clocks/bit -> exactly one rx_data_rdy pulse; rx_data=8'h41; rx_frm_err never high; rx_busy high ~1000 clocks.
- Back-to-back: send 8'h31, 8'h32, 8'h0D with no idle gap -> three rdy pulses, values in order, none dropped.
- Glitch rejection: drive a 20-clock low pulse on rx_pin -> returns to IDLE, no rdy and no err pulse. Then send 8'h55 -> received as 8'h55.
- Framing error: send 8'hA5 with the stop bit low, then hold low 3000 clocks -> one rx_frm_err pulse, rx_data keeps its previous value, no further pulses. Release high, send 8'h7E -> rdy with 8'h7E.
- Baud tolerance: send 8'hC3 at 100 and at 108 clocks/bit (about ±4%) -> received correctly in both cases. Also assert rst=0 mid-frame -> outputs clear immediately and the next clean frame is received.
